// File: rtl/analog_scan_ctrl_pkg.sv
// Shared types and constants for the analog scan scheduler.
package analog_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSelect  = 3'd1,
    StSettle  = 3'd2,
    StCapture = 3'd3,
    StUpdate  = 3'd4,
    StDone    = 3'd5
  } scan_state_e;

  // Host write to this address clears the overrun flag instead of touching the image.
  localparam logic [3:0] OvrClrAddr = 4'd15;

endpackage

// File: rtl/analog_scan_ctrl_if.sv
// Scan handshake and image register bus between the PLC core and the scan scheduler.
interface analog_scan_ctrl_if #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned CHANNELS = 4
) ();

  logic                scan_start;
  logic [CHANNELS-1:0] dir_mask;
  logic                scan_busy;
  logic                scan_done;
  logic                scan_ovr;
  logic [3:0]          img_addr;
  logic                img_wr;
  logic [BITS-1:0]     img_wdata;
  logic [BITS-1:0]     img_rdata;

  modport master (
    output scan_start, dir_mask, img_addr, img_wr, img_wdata,
    input  scan_busy, scan_done, scan_ovr, img_rdata
  );

  modport slave (
    input  scan_start, dir_mask, img_addr, img_wr, img_wdata,
    output scan_busy, scan_done, scan_ovr, img_rdata
  );

endinterface

// File: rtl/analog_image_regs.sv
// Input/output image register file with output latches, same-cycle write bypass
// into the latch being updated, and combinational image readback.
module analog_image_regs #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ChW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               img_addr_i,
  input  logic                     img_wr_i,
  input  logic [BITS-1:0]          img_wdata_i,
  output logic [BITS-1:0]          img_rdata_o,
  input  logic                     cap_en_i,
  input  logic                     upd_en_i,
  input  logic [ChW-1:0]           ch_i,
  input  logic [CHANNELS*BITS-1:0] io_dout_i,
  output logic [CHANNELS*BITS-1:0] io_din_o
);

  logic [BITS-1:0] out_img_q [CHANNELS];
  logic [BITS-1:0] out_img_d [CHANNELS];
  logic [BITS-1:0] in_img_q  [CHANNELS];
  logic [BITS-1:0] in_img_d  [CHANNELS];
  logic [BITS-1:0] latch_q   [CHANNELS];
  logic [BITS-1:0] latch_d   [CHANNELS];
  logic            wr_hit;

  always_comb begin
    wr_hit    = img_wr_i && (32'(img_addr_i) < CHANNELS);
    out_img_d = out_img_q;
    in_img_d  = in_img_q;
    latch_d   = latch_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (wr_hit && (32'(img_addr_i) == k)) out_img_d[k] = img_wdata_i;
      if (cap_en_i && (ch_i == ChW'(k))) in_img_d[k] = io_dout_i[k*BITS +: BITS];
      // Latch from the post-write image so a write to the updating channel bypasses.
      if (upd_en_i && (ch_i == ChW'(k))) latch_d[k] = out_img_d[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_img_q <= '{default: '0};
      in_img_q  <= '{default: '0};
      latch_q   <= '{default: '0};
    end else begin
      out_img_q <= out_img_d;
      in_img_q  <= in_img_d;
      latch_q   <= latch_d;
    end
  end

  always_comb begin
    img_rdata_o = '0;
    io_din_o    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(img_addr_i) == k) img_rdata_o = in_img_q[k];
      io_din_o[k*BITS +: BITS] = latch_q[k];
    end
  end

endmodule

// File: rtl/analog_scan_ctrl.sv
// PLC analog scan scheduler: captures input channels, commits output latches, one start/done.
// Optional feature: define ANALOG_SCAN_OVERRUN_EN for the sticky scan_ovr flag.
module analog_scan_ctrl
  import analog_scan_ctrl_pkg::*;
#(
  parameter int unsigned BITS     = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  analog_scan_ctrl_if.slave        bus,
  output logic [CHANNELS-1:0]      io_en,
  output logic [CHANNELS-1:0]      io_dir,
  output logic [CHANNELS*BITS-1:0] io_din,
  input  logic [CHANNELS*BITS-1:0] io_dout
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ChW-1:0]  LastCh  = ChW'(CHANNELS - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE - 1);

  scan_state_e         state_q, state_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic                cap_en, upd_en, img_wr_img;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    cap_en  = 1'b0;
    upd_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.scan_start) begin
          mask_d  = bus.dir_mask;
          ch_d    = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        cnt_d = '0;
        if (mask_q[ch_q]) begin
          state_d = StUpdate;
        end else begin
          dir_d[ch_q] = 1'b0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == LastCnt) state_d = StCapture;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StCapture, StUpdate: begin
        if (state_q == StCapture) begin
          cap_en = 1'b1;
        end else begin
          upd_en      = 1'b1;
          dir_d[ch_q] = 1'b1;
        end
        if (ch_q == LastCh) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + ChW'(1);
          state_d = StSelect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    io_en = '0;
    if (state_q inside {StSelect, StSettle, StCapture, StUpdate}) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (ch_q == ChW'(k)) io_en[k] = 1'b1;
      end
    end
  end

  assign io_dir        = dir_q;
  assign bus.scan_busy = (state_q != StIdle);
  assign bus.scan_done = (state_q == StDone);

`ifdef ANALOG_SCAN_OVERRUN_EN
  logic ovr_q, ovr_d, ovr_clr;

  always_comb begin
    ovr_clr = bus.img_wr && (bus.img_addr == OvrClrAddr);
    ovr_d   = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (bus.scan_start && !(state_q inside {StIdle, StDone})) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign bus.scan_ovr = ovr_q;
  assign img_wr_img   = bus.img_wr && !ovr_clr;
`else
  assign bus.scan_ovr = 1'b0;
  assign img_wr_img   = bus.img_wr;
`endif

  analog_image_regs #(
    .BITS     (BITS),
    .CHANNELS (CHANNELS),
    .ChW      (ChW)
  ) u_image_regs (
    .clk         (clk),
    .rst         (rst),
    .img_addr_i  (bus.img_addr),
    .img_wr_i    (img_wr_img),
    .img_wdata_i (bus.img_wdata),
    .img_rdata_o (bus.img_rdata),
    .cap_en_i    (cap_en),
    .upd_en_i    (upd_en),
    .ch_i        (ch_q),
    .io_dout_i   (io_dout),
    .io_din_o    (io_din)
  );

endmodule
